adc_sample_capture: RTL and testbench

//  Front end of the FIR chain: paces the sample rate, runs one read frame per sample
//   on an external serial ADC (CS_N/SCLK/SDO, MSB first), and presents a 16-bit
//   two's-complement word to the transposed-form FIR filter input.

---
 rtl/filter_pkg.sv | 14 +
 rtl/sample_rate_gen.sv | 41 ++++
 rtl/adc_sample_capture.sv | 165 ++++++++++++++++
 tb/tb_adc_sample_capture.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the FIR signal chain: sample width and ADC front-end states.
package filter_pkg;

  // FIR coefficient/input word width; the ADC front end delivers words of this size.
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } adc_state_t;

endpackage

// File: rtl/sample_rate_gen.sv
// Modulo-DIV sample-rate counter. Emits tick on the last count while enabled.
// The count is held at zero while disabled, so the first tick after enable
// lands on the DIV-th enabled cycle.
module sample_rate_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: wrap at DIV-1, hold at zero while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/adc_sample_capture.sv
// ADC sample capture: paces the sample rate, runs one CS_N/SCLK/SDO read frame
// per sample (MSB first) and presents a two's-complement word to the FIR input.
module adc_sample_capture
  import filter_pkg::*;
#(
  parameter int DATA_W     = filter_pkg::DATA_W,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 1000,
  parameter int OFFSET_BIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] xout,
  output logic              xout_valid,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam int unsigned       DATA_WU  = DATA_W;
  localparam logic [DATA_W-1:0] MSB_FLIP =
    (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  adc_state_t        state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shreg_in;
  logic [DATA_W-1:0] xout_q, xout_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              sdo_q;
  logic              tick;

  sample_rate_gen #(
    .DIV (SAMPLE_DIV)
  ) u_rate (
    .clk    (clk),
    .rst_n  (rst),
    .en_i   (enable),
    .tick_o (tick)
  );

  // Next-state and next-output logic. Pin-level outputs are computed for the
  // state being entered so the registered pins line up with that state.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    xout_d  = xout_q;
    cs_n_d  = 1'b1;
    sclk_d  = 1'b0;
    valid_d = 1'b0;

    // Bits past DATA_W are clocked through but not kept.
    if ({{(32-BIT_W){1'b0}}, bit_q} < DATA_WU) begin
      shreg_in = {shreg_q[DATA_W-2:0], sdo_q};
    end else begin
      shreg_in = shreg_q;
    end

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          ph_d    = '0;
          bit_d   = '0;
          shreg_d = '0;
          cs_n_d  = 1'b0;
        end
      end
      SETUP: begin
        cs_n_d = 1'b0;
        if (ph_q == PH_LAST) begin
          state_d = SHIFT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = sclk_q;
        if (ph_q != PH_LAST) begin
          ph_d = ph_q + PH_W'(1);
        end else begin
          ph_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            shreg_d = shreg_in;
            if (bit_q == BIT_LAST) begin
              state_d = DONE;
              cs_n_d  = 1'b1;
              valid_d = 1'b1;
              xout_d  = shreg_in ^ MSB_FLIP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Sticky overrun; a dropped tick wins over a simultaneous clear.
    ovr_d = ovr_q;
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end
    if (tick && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  // State, counters, shifter, input synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      xout_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      xout_q  <= xout_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      sdo_q   <= adc_sdo;
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign xout       = xout_q;
  assign xout_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Bench for adc_sample_capture: three instances (defaults, short sample period,
// 18-bit offset-free frames), each fed by a serial ADC model that shifts its
// frame out MSB first, changing SDO on CS_N and SCLK falling edges.
module tb_adc_sample_capture;

  localparam int SDIV   = 1000;
  localparam int SDIV_B = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- instance A: default parameters ----------------
  logic        a_rst, a_en, a_sdo, a_cs_n, a_sclk, a_valid, a_ovr, a_clr;
  logic [15:0] a_xout;
  adc_sample_capture dut_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .adc_sdo(a_sdo),
    .adc_cs_n(a_cs_n), .adc_sclk(a_sclk), .xout(a_xout),
    .xout_valid(a_valid), .overrun(a_ovr), .overrun_clr(a_clr)
  );

  // ---------------- instance B: short sample period ----------------
  logic        b_rst, b_en, b_sdo, b_cs_n, b_sclk, b_valid, b_ovr, b_clr;
  logic [15:0] b_xout;
  adc_sample_capture #(.SAMPLE_DIV(SDIV_B)) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .adc_sdo(b_sdo),
    .adc_cs_n(b_cs_n), .adc_sclk(b_sclk), .xout(b_xout),
    .xout_valid(b_valid), .overrun(b_ovr), .overrun_clr(b_clr)
  );

  // ---------------- instance C: 18-bit frame, pass-through ----------------
  logic        c_rst, c_en, c_sdo, c_cs_n, c_sclk, c_valid, c_ovr, c_clr;
  logic [15:0] c_xout;
  adc_sample_capture #(.FRAME_BITS(18), .OFFSET_BIN(0)) dut_c (
    .clk(clk), .rst(c_rst), .enable(c_en), .adc_sdo(c_sdo),
    .adc_cs_n(c_cs_n), .adc_sclk(c_sclk), .xout(c_xout),
    .xout_valid(c_valid), .overrun(c_ovr), .overrun_clr(c_clr)
  );

  // ---------------- serial ADC models ----------------
  logic [31:0] a_frame = '0, b_frame = '0, c_frame = '0;
  int a_idx = 0, b_idx = 0, c_idx = 0;
  int a_csfalls = 0;

  always @(negedge a_cs_n) begin a_idx = 15; a_sdo = a_frame[a_idx]; a_csfalls++; end
  always @(negedge a_sclk) if (a_idx > 0) begin a_idx = a_idx - 1; a_sdo = a_frame[a_idx]; end
  always @(negedge b_cs_n) begin b_idx = 15; b_sdo = b_frame[b_idx]; end
  always @(negedge b_sclk) if (b_idx > 0) begin b_idx = b_idx - 1; b_sdo = b_frame[b_idx]; end
  always @(negedge c_cs_n) begin c_idx = 17; c_sdo = c_frame[c_idx]; end
  always @(negedge c_sclk) if (c_idx > 0) begin c_idx = c_idx - 1; c_sdo = c_frame[c_idx]; end

  // ---------------- activity monitors for instance A ----------------
  int a_nvalid = 0, a_rises = 0, a_csrun = 0, a_cslen = 0;
  always @(posedge a_sclk) a_rises++;
  always @(negedge clk) begin
    if (a_valid === 1'b1) a_nvalid++;
    if (a_cs_n === 1'b0) a_csrun++;
    else if (a_csrun != 0) begin a_cslen = a_csrun; a_csrun = 0; end
  end

  // ---------------- reference model ----------------
  // Kept word = first 16 bits of the frame, MSB inverted for offset-binary.
  function automatic logic [15:0] exp_xout(input logic [31:0] frame, input int fbits, input bit ob);
    logic [31:0] w;
    w = frame >> (fbits - 16);
    return w[15:0] ^ (ob ? 16'h8000 : 16'h0000);
  endfunction

  // tick-to-valid latency
  function automatic int unsigned lat(input int fbits);
    return 4 * (2 * fbits + 1) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call only at a negedge; returns at the negedge where cyc == t.
  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int unsigned t0, tv, r0, e2, nv0, f0, tb, busy;
    int unsigned acc[$];
    int unsigned drp[$];
    logic [15:0] seq[$];

    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_en  = 1'b0; b_en  = 1'b0; c_en  = 1'b0;
    a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
    a_sdo = 1'b0; b_sdo = 1'b0; c_sdo = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs_n",  a_cs_n,  1);
    check("rst_sclk",  a_sclk,  0);
    check("rst_xout",  a_xout,  0);
    check("rst_valid", a_valid, 0);
    check("rst_ovr",   a_ovr,   0);
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    @(negedge clk);

    // 1: first frame after enable, all-ones word
    a_frame = 32'h0000_FFFF;
    a_rises = 0;
    t0 = cyc;
    a_en = 1'b1;
    tv = t0 + SDIV - 1 + lat(16);
    wait_until(tv - 1);
    check("t1_early_valid", a_valid, 0);
    @(negedge clk);
    check("t1_valid", a_valid, 1);
    check("t1_xout", a_xout, exp_xout(a_frame, 16, 1'b1));
    @(negedge clk);
    check("t1_cs_low_len", a_cslen, 132);
    check("t1_sclk_rises", a_rises, 16);
    check("t1_valid_pulse", a_valid, 0);
    check("t1_xout_held", a_xout, 16'h7FFF);

    // 2: consecutive words plus random ones, 1000 clk apart
    seq = '{16'h8000, 16'h0000, 16'h1234};
    seq.push_back(16'($urandom));
    seq.push_back(16'($urandom));
    for (int n = 0; n < seq.size(); n++) begin
      a_frame = {16'h0000, seq[n]};
      tv = tv + SDIV;
      wait_until(tv - 1);
      check($sformatf("t2_early_valid%0d", n), a_valid, 0);
      @(negedge clk);
      check($sformatf("t2_valid%0d", n), a_valid, 1);
      check($sformatf("t2_xout%0d", n), a_xout, exp_xout(a_frame, 16, 1'b1));
    end
    @(negedge clk);
    check("t2_valid_count", a_nvalid, 1 + seq.size());

    // 4: reset at the 8th SCLK rising edge of a frame
    a_frame = $urandom & 32'h0000_FFFF;
    a_rises = 0;
    for (int i = 0; i < 1200 && a_rises < 8; i++) @(negedge clk);
    check("t4_reached_8th_sclk", a_rises, 8);
    nv0 = a_nvalid;
    a_rst = 1'b0;
    #1;
    check("t4_cs_n", a_cs_n, 1);
    check("t4_sclk", a_sclk, 0);
    check("t4_xout", a_xout, 0);
    check("t4_valid", a_valid, 0);
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
    r0 = cyc;
    a_frame = $urandom & 32'h0000_FFFF;
    tv = r0 + SDIV - 1 + lat(16);
    wait_until(tv - 1);
    check("t4_no_valid_after_abort", a_nvalid, nv0);
    @(negedge clk);
    check("t4_valid", a_valid, 1);
    check("t4_fresh_xout", a_xout, exp_xout(a_frame, 16, 1'b1));

    // 5: enable dropped mid-frame, then re-enabled
    a_frame = $urandom & 32'h0000_FFFF;
    wait_until(tv + 930);
    check("t5_mid_frame", a_cs_n, 0);
    a_en = 1'b0;
    tv = tv + SDIV;
    wait_until(tv - 1);
    check("t5_early_valid", a_valid, 0);
    @(negedge clk);
    check("t5_valid", a_valid, 1);
    check("t5_xout", a_xout, exp_xout(a_frame, 16, 1'b1));
    @(negedge clk);
    f0 = a_csfalls;
    nv0 = a_nvalid;
    wait_until(tv + 5001);
    check("t5_no_cs_activity", a_csfalls, f0);
    check("t5_no_valid", a_nvalid, nv0);
    a_frame = $urandom & 32'h0000_FFFF;
    e2 = cyc;
    a_en = 1'b1;
    tv = e2 + SDIV - 1 + lat(16);
    wait_until(tv - 1);
    check("t5_reen_early", a_valid, 0);
    @(negedge clk);
    check("t5_reen_valid", a_valid, 1);
    check("t5_reen_xout", a_xout, exp_xout(a_frame, 16, 1'b1));
    a_en = 1'b0;

    // 3: sample period shorter than a frame; ticks are accepted only when idle
    b_frame = $urandom & 32'h0000_FFFF;
    tb = cyc;
    b_en = 1'b1;
    busy = 0;
    for (int k = 0; k < 7; k++) begin
      int unsigned t;
      t = tb + SDIV_B - 1 + SDIV_B * k;
      if (t > busy) begin acc.push_back(t); busy = t + lat(16); end
      else drp.push_back(t);
    end
    wait_until(drp[0]);
    check("t3_ovr_before_drop", b_ovr, 0);
    @(negedge clk);
    check("t3_ovr_set", b_ovr, 1);
    wait_until(acc[0] + lat(16));
    check("t3_valid0", b_valid, 1);
    check("t3_xout0", b_xout, exp_xout(b_frame, 16, 1'b1));
    b_frame = $urandom & 32'h0000_FFFF;
    wait_until(drp[0] + 51);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    check("t3_clr_alone", b_ovr, 0);
    wait_until(drp[1]);
    check("t3_ovr_still_clear", b_ovr, 0);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    check("t3_set_beats_clr", b_ovr, 1);
    wait_until(acc[1] + lat(16) - 1);
    check("t3_early_valid1", b_valid, 0);
    @(negedge clk);
    check("t3_valid1", b_valid, 1);
    check("t3_xout1", b_xout, exp_xout(b_frame, 16, 1'b1));
    b_frame = $urandom & 32'h0000_FFFF;
    wait_until(acc[2] + lat(16));
    check("t3_valid2", b_valid, 1);
    check("t3_xout2", b_xout, exp_xout(b_frame, 16, 1'b1));
    b_en = 1'b0;

    // 6: 18-bit frame, pass-through coding
    c_frame = {14'b0, 16'hA5C3, 2'b11};
    t0 = cyc;
    c_en = 1'b1;
    tv = t0 + SDIV - 1 + lat(18);
    wait_until(tv - 1);
    check("t6_early_valid", c_valid, 0);
    @(negedge clk);
    check("t6_valid", c_valid, 1);
    check("t6_xout", c_xout, exp_xout(c_frame, 18, 1'b0));
    c_frame = $urandom & 32'h0003_FFFF;
    tv = tv + SDIV;
    wait_until(tv);
    check("t6_valid_rand", c_valid, 1);
    check("t6_xout_rand", c_xout, exp_xout(c_frame, 18, 1'b0));
    check("t6_no_overrun", c_ovr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
